dmem_responder: RTL

//  Data-memory responder for the RV32I datapath's load/store port. Accepts one request at a time
//  (address from ALU result, store data from rs2, funct3 for width/sign), applies byte-lane

---
 rtl/rv_mem_pkg.sv | 31 +++
 rtl/dmem_ram.sv | 27 ++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32I data-memory port: funct3 codes, responder
// state encoding and access-legality helpers.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Reserved funct3 codes, plus unsigned widths which only exist for loads.
  function automatic logic is_illegal(input logic [2:0] f3, input logic st);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port 32-bit data RAM with per-byte write enables and registered read.
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: captures one request, checks legality, inserts wait
// states, performs the lane-selected RAM access and returns a one-cycle ready.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  f3,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        fault
);
  import rv_mem_pkg::*;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic              fault_q;

  logic              in_fault;
  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wd;
  logic [31:0]       ram_q;
  logic [31:0]       lane;
  logic [31:0]       load_ext;

  always_comb begin
    in_fault = (addr[31:ADDR_W+2] != '0) || is_misaligned(f3, addr[1:0]) || is_illegal(f3, we);
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    ram_be = 4'hf;
    ram_wd = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        ram_be = 4'b0001 << addr_q[1:0];
        ram_wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ram_be = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_wd = {2{wdata_q[15:0]}};
      end
      default: begin
        ram_be = 4'hf;
        ram_wd = wdata_q;
      end
    endcase
  end

  assign ram_en = (state == S_ACCESS);
  assign ram_we = (state == S_ACCESS) && we_q;

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (addr_q[ADDR_W+1:2]),
    .wdata (ram_wd),
    .rdata (ram_q)
  );

  // Halfwords are aligned, so the byte shift also covers the 16*addr[1] case.
  always_comb begin
    lane     = ram_q >> {addr_q[1:0], 3'b000};
    load_ext = lane;
    case (f3_q)
      F3_B:    load_ext = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   load_ext = {24'd0, lane[7:0]};
      F3_H:    load_ext = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      f3_q     <= 3'd0;
      fault_q  <= 1'b0;
      ready    <= 1'b0;
      rdata    <= 32'd0;
      fault    <= 1'b0;
    end else begin
      ready <= 1'b0;
      rdata <= 32'd0;
      fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
            f3_q    <= f3;
            fault_q <= in_fault;
            if (in_fault) begin
              state <= S_RESP;
            end else if (WAIT_CYCLES == 0) begin
              state <= S_ACCESS;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_ACCESS;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_ACCESS: begin
          state <= S_RESP;
        end
        S_RESP: begin
          ready <= 1'b1;
          fault <= fault_q;
          rdata <= (fault_q || we_q) ? 32'd0 : load_ext;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
